alu_instr_sequencer: RTL and testbench

- Parametrised control sequencer for the datapath's three-register ALU instructions (op Ra, Rb, Rc).
- Generates the fetch/execute control strobes that are currently hand-driven by state in benches, for one instruction per Start request.
- Generalises register count and data width. Adds a memory-ready handshake with timeout, illegal-instruction detection, a Done handshake and a retired-instruction counter.

---
 rtl/alu_instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for three-register ALU instructions (op Ra, Rb, Rc).
// One instruction per Start request; strobes are decoded from the state register.
module alu_instr_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Mem_ready,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [4:0]          AluOp,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal,
  output logic                Error,
  output logic [CNT_W-1:0]    InstrCount
);

  localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_FIN, S_BAD, S_ABORT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;

  logic [4:0] w_opcode;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_op_ok, w_idx_ok, w_legal;
  logic       w_unused_ir;

  assign w_opcode    = IR[31:27];
  assign w_ra        = IR[26:23];
  assign w_rb        = IR[22:19];
  assign w_rc        = IR[18:15];
  assign w_unused_ir = ^IR;

  assign w_op_ok  = (w_opcode >= 5'd3) && (w_opcode <= 5'd10);
  assign w_idx_ok = ({1'b0, w_ra} < 5'(NUM_REGS)) &&
                    ({1'b0, w_rb} < 5'(NUM_REGS)) &&
                    ({1'b0, w_rc} < 5'(NUM_REGS));
  assign w_legal  = w_op_ok && w_idx_ok;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T0)
        r_wait <= '0;
      else if (r_state == S_T1 && !Mem_ready)
        r_wait <= r_wait + WCNT_W'(1);
      if (r_state == S_FIN)
        r_count <= r_count + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Rout    = '0;
    Rin     = '0;
    AluOp   = '0;
    Done    = 1'b0;
    Illegal = 1'b0;
    Error   = 1'b0;
    case (r_state)
      S_IDLE: if (Start) w_next = S_T0;
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // PC is written back only once, however long the memory stalls.
        if (r_wait == '0) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
        if (Mem_ready)               w_next = S_T2;
        else if (r_wait == WAIT_LAST) w_next = S_ABORT;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (!w_legal) begin
          w_next = S_BAD;
        end else begin
          Rout   = NUM_REGS'(1) << w_rb;
          Yin    = 1'b1;
          w_next = S_T4;
        end
      end
      S_T4: begin
        Rout   = NUM_REGS'(1) << w_rc;
        Zin    = 1'b1;
        AluOp  = w_opcode;
        w_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        Rin     = NUM_REGS'(1) << w_ra;
        w_next  = S_FIN;
      end
      S_FIN: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      S_BAD: begin
        Illegal = 1'b1;
        w_next  = S_IDLE;
      end
      S_ABORT: begin
        Error  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign Busy       = (r_state != S_IDLE);
  assign InstrCount = r_count;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: default instance plus a NUM_REGS=8 instance
// for the out-of-range register index case.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Start, Mem_ready, Start_8;
  logic [31:0] IR, IR_8;

  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [15:0] Rout, Rin;
  logic [4:0]  AluOp;
  logic        Busy, Done, Illegal, Error;
  logic [15:0] InstrCount;

  logic        PCout_8, Zlowout_8, MDRout_8, MARin_8, Zin_8, PCin_8, MDRin_8, IRin_8;
  logic        Yin_8, IncPC_8, Read_8;
  logic [7:0]  Rout_8, Rin_8;
  logic [4:0]  AluOp_8;
  logic        Busy_8, Done_8, Illegal_8, Error_8;
  logic [15:0] InstrCount_8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  alu_instr_sequencer u_dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Rout(Rout), .Rin(Rin), .AluOp(AluOp), .Busy(Busy), .Done(Done),
    .Illegal(Illegal), .Error(Error), .InstrCount(InstrCount)
  );

  alu_instr_sequencer #(.NUM_REGS(8)) u_dut8 (
    .Clock(Clock), .Reset(Reset), .Start(Start_8), .Mem_ready(Mem_ready), .IR(IR_8),
    .PCout(PCout_8), .Zlowout(Zlowout_8), .MDRout(MDRout_8), .MARin(MARin_8), .Zin(Zin_8),
    .PCin(PCin_8), .MDRin(MDRin_8), .IRin(IRin_8), .Yin(Yin_8), .IncPC(IncPC_8),
    .Read(Read_8), .Rout(Rout_8), .Rin(Rin_8), .AluOp(AluOp_8), .Busy(Busy_8),
    .Done(Done_8), .Illegal(Illegal_8), .Error(Error_8), .InstrCount(InstrCount_8)
  );

  logic [10:0] strobes;
  assign strobes = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Start_8 = 1'b0; Mem_ready = 1'b1;
    IR = 32'h0; IR_8 = 32'h0;
    tick(); tick();
    Reset = 1'b0;
    check("rst_strobes", 32'(strobes), 32'h0);
    check("rst_rout_rin", {Rout, Rin}, 32'h0);
    check("rst_flags", {AluOp, Busy, Done, Illegal, Error}, 32'h0);
    check("rst_count", 32'(InstrCount), 32'h0);

    // 1: AND R1,R2,R3 with memory always ready
    IR = 32'h28918000; Start = 1'b1;
    tick(); Start = 1'b0;                                  // T0
    check("t1_t0", {PCout, MARin, IncPC, Zin, Busy}, 32'h1f);
    tick();                                                // T1
    check("t1_t1", {Zlowout, PCin, Read, MDRin}, 32'hf);
    tick();                                                // T2
    check("t1_t2", {MDRout, IRin}, 32'h3);
    tick();                                                // T3
    check("t1_t3_rout", 32'(Rout), 32'h0004);
    check("t1_t3_yin", 32'(Yin), 32'h1);
    tick();                                                // T4
    check("t1_t4", {Rout, 10'h0, Zin, AluOp}, {16'h0008, 10'h0, 1'b1, 5'd5});
    tick();                                                // T5
    check("t1_t5", {Rin, Rout}, {16'h0002, 16'h0000});
    check("t1_t5_zlow", 32'(Zlowout), 32'h1);
    tick();                                                // FIN, 7 edges after Start
    check("t1_done", {Done, Illegal, Error}, 32'h4);
    tick();
    check("t1_idle", {Busy, Done}, 32'h0);
    check("t1_count", 32'(InstrCount), 32'h1);

    // 2: three stall cycles in T1
    Mem_ready = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0;                                  // T0
    tick();                                                // T1 #1
    check("t2_t1a", {Read, MDRin, PCin, Zlowout}, 32'hf);
    tick();                                                // T1 #2
    check("t2_t1b", {Read, MDRin, PCin, Zlowout}, 32'hc);
    tick();                                                // T1 #3
    check("t2_t1c", {Read, MDRin, PCin}, 32'h6);
    tick(); Mem_ready = 1'b1;                              // T1 #4
    check("t2_t1d", {Read, MDRin, PCin}, 32'h6);
    tick();                                                // T2
    check("t2_t2", {Read, MDRout, IRin}, 32'h3);
    tick(); tick(); tick();                                // T3..T5
    check("t2_t5_rin", 32'(Rin), 32'h0002);
    tick();                                                // FIN at edge 10
    check("t2_done", 32'(Done), 32'h1);
    tick();
    check("t2_count", 32'(InstrCount), 32'h2);

    // 3: illegal opcode on default instance, Ra=9 on NUM_REGS=8 instance
    IR = 32'hF8000000; IR_8 = 32'h1C800000;
    Start = 1'b1; Start_8 = 1'b1;
    tick(); Start = 1'b0; Start_8 = 1'b0;
    tick(); tick(); tick();                                // T3
    check("t3_t3", {Rout, Rin}, 32'h0);
    check("t3_t3_yin", {Yin, Busy, Yin_8, Busy_8}, 32'h5);
    tick();                                                // BAD
    check("t3_bad", {Illegal, Done, Error}, 32'h4);
    check("t3_bad_regs", {Rout, Rin}, 32'h0);
    check("t3_bad8", {Illegal_8, Done_8, Error_8}, 32'h4);
    check("t3_bad8_regs", {Rout_8, Rin_8}, 32'h0);
    tick();
    check("t3_count", {InstrCount, InstrCount_8}, {16'h2, 16'h0});
    check("t3_idle", {Busy, Busy_8, Illegal, Illegal_8}, 32'h0);

    // 4: Mem_ready never arrives, abort after WAIT_MAX=8 T1 cycles
    IR = 32'h28918000; Mem_ready = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0;                                  // T0
    for (int i = 0; i < 8; i++) tick();                    // T1 x8
    check("t4_t1_last", {Read, MDRin, Error}, 32'h6);
    tick();                                                // ABORT
    check("t4_abort", {Error, Read, MDRin, Done, Illegal}, 32'h10);
    tick();
    check("t4_idle", {Busy, Error}, 32'h0);
    Mem_ready = 1'b1; Start = 1'b1;
    tick(); Start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t4_rerun_done", 32'(Done), 32'h1);
    tick();
    check("t4_count", 32'(InstrCount), 32'h3);

    // 5: reset during T4, then Start while busy
    Start = 1'b1;
    tick(); Start = 1'b0;
    tick(); tick(); tick(); tick();                        // T4
    check("t5_t4_aluop", 32'(AluOp), 32'h5);
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    check("t5_rst_strobes", 32'(strobes), 32'h0);
    check("t5_rst_misc", {Rout, Rin}, 32'h0);
    check("t5_rst_flags", {AluOp, Busy, Done, Illegal, Error}, 32'h0);
    check("t5_rst_count", 32'(InstrCount), 32'h0);
    Start = 1'b1;
    tick(); Start = 1'b0;                                  // T0
    tick(); tick(); Start = 1'b1;                          // T2, Start while busy
    tick(); Start = 1'b0;                                  // T3
    tick(); tick(); tick();                                // FIN
    check("t5_done", 32'(Done), 32'h1);
    tick(); tick();                                        // IDLE, IDLE
    check("t5_ignored", 32'(Busy), 32'h0);
    check("t5_count", 32'(InstrCount), 32'h1);

    // 6: back-to-back ADD R15,R14,R13 with Start held high
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    IR = 32'h1FF68000; Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();                                              // T0
      check($sformatf("t6_t0_%0d", i), {Busy, PCout}, 32'h3);
      tick(); tick(); tick();                              // T3
      check($sformatf("t6_t3_%0d", i), 32'(Rout), 32'h4000);
      tick();                                              // T4
      check($sformatf("t6_t4_%0d", i), {Rout, 11'h0, AluOp}, {16'h2000, 11'h0, 5'd3});
      tick();                                              // T5
      check($sformatf("t6_t5_%0d", i), {Rin, Rout}, {16'h8000, 16'h0000});
      tick();                                              // FIN
      check($sformatf("t6_done_%0d", i), 32'(Done), 32'h1);
      tick();                                              // single IDLE gap
      check($sformatf("t6_gap_%0d", i), 32'(Busy), 32'h0);
    end
    Start = 1'b0;
    tick();
    check("t6_stop", 32'(Busy), 32'h0);
    check("t6_count", 32'(InstrCount), 32'h3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
